// File: rtl/decimate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decimate_pkg
//  Description : Shared helpers for the averaging decimator (log2, ratio check)
//  Revision    : 1.0 - initial release
// ============================================================================

package decimate_pkg;

    // Floor log2; exact for the power-of-two ratios this block accepts.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value; v > 1; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic bit ratio_legal(input int unsigned ratio);
        return (ratio >= 2) && ((ratio & (ratio - 1)) == 0);
    endfunction

endpackage : decimate_pkg

`default_nettype wire

// File: rtl/decim_accum.sv
`default_nettype none
// ============================================================================
//  Module      : decim_accum
//  Description : Block sample counter and running-sum accumulator
//  Revision    : 1.0 - initial release
// ============================================================================

module decim_accum
    import decimate_pkg::*;
#(
    parameter int unsigned width_p = 8,
    parameter int unsigned ratio_p = 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_ni,
    input  logic                                 i_in_fire,
    input  logic [width_p-1:0]                   i_data,
    output logic                                 o_last,
    output logic [width_p+log2(ratio_p)-1:0]     o_sum
);

    localparam int unsigned c_shift = log2(ratio_p);
    localparam int unsigned c_acc_w = width_p + c_shift;
    localparam logic [c_shift-1:0] c_last = c_shift'(ratio_p - 1);

    logic [c_shift-1:0] r_count;
    logic [c_acc_w-1:0] r_acc;
    logic [c_acc_w-1:0] w_sum;

    // Sum including the current sample, so the top can load the mean on the final beat.
    assign w_sum  = r_acc + c_acc_w'(i_data);
    assign o_sum  = w_sum;
    assign o_last = (r_count == c_last);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_count <= '0;
            r_acc   <= '0;
        end else if (i_in_fire) begin
            if (o_last) begin
                r_count <= '0;
                r_acc   <= '0;
            end else begin
                r_count <= r_count + 1'b1;
                r_acc   <= w_sum;
            end
        end
    end

endmodule : decim_accum

`default_nettype wire

// File: rtl/decimate_avg.sv
`default_nettype none
// ============================================================================
//  Module      : decimate_avg
//  Description : Block-mean decimator with a single-entry registered output
//  Revision    : 1.0 - initial release
// ============================================================================

module decimate_avg
    import decimate_pkg::*;
#(
    parameter int unsigned width_p = 8,
    parameter int unsigned ratio_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [width_p-1:0] data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               valid_o,
    input  logic               ready_i
);

    localparam int unsigned c_shift = log2(ratio_p);
    localparam int unsigned c_acc_w = width_p + c_shift;

    if (!ratio_legal(ratio_p)) begin : g_bad_ratio
        $error("decimate_avg: ratio_p must be a power of two >= 2");
    end

    logic               w_last;
    logic [c_acc_w-1:0] w_sum;
    logic [width_p-1:0] w_mean;
    logic               w_in_fire;
    logic               w_out_fire;
    logic [width_p-1:0] r_data;
    logic               r_valid;

    // Only the block-completing sample needs room in the output slot.
    assign ready_o    = !w_last || !r_valid || ready_i;
    assign w_in_fire  = valid_i && ready_o;
    assign w_out_fire = r_valid && ready_i;
    assign w_mean     = w_sum[c_acc_w-1:c_shift];

    decim_accum #(
        .width_p (width_p),
        .ratio_p (ratio_p)
    ) u_accum (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .i_in_fire (w_in_fire),
        .i_data    (data_i),
        .o_last    (w_last),
        .o_sum     (w_sum)
    );

    // A new result takes priority over draining, giving bubble-free back-to-back output.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_in_fire && w_last) begin
            r_valid <= 1'b1;
            r_data  <= w_mean;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;

endmodule : decimate_avg

`default_nettype wire

// File: tb/tb_decimate_avg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decimate_avg
//  Description : Directed self-checking bench for decimate_avg (8-bit, ratio 4)
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_decimate_avg;

    logic       clk_i;
    logic       reset_ni;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;

    int total = 0;
    int bad   = 0;

    decimate_avg #(
        .width_p (8),
        .ratio_p (4)
    ) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        valid_i = 1'b1;
        data_i  = d;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        data_i  = 8'hEE;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        reset_ni = 1'b0;
        valid_i  = 1'b0;
        data_i   = 8'd0;
        ready_i  = 1'b1;

        // reset state
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_ready", ready_o, 1);
        valid_i = 1'b1;
        data_i  = 8'd77;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready_held", ready_o, 1);
        check("rst_valid_held", valid_o, 0);
        valid_i  = 1'b0;
        reset_ni = 1'b1;

        // basic mean
        send(8'd10); send(8'd20); send(8'd30);
        check("basic_pre_valid", valid_o, 0);
        send(8'd40);
        check("basic_valid", valid_o, 1);
        check("basic_data", data_o, 25);
        idle(1);
        check("basic_drain_valid", valid_o, 0);
        check("basic_hold_data", data_o, 25);

        // full scale and floor
        send(8'd255); send(8'd255); send(8'd255); send(8'd255);
        check("full_valid", valid_o, 1);
        check("full_data", data_o, 255);
        send(8'd1);
        check("floor_drained", valid_o, 0);
        send(8'd1); send(8'd1); send(8'd2);
        check("floor_valid", valid_o, 1);
        check("floor_data", data_o, 1);
        idle(1);
        check("floor_drain", valid_o, 0);

        // backpressure
        ready_i = 1'b0;
        send(8'd10); send(8'd20); send(8'd30); send(8'd40);
        check("bp_first_valid", valid_o, 1);
        check("bp_first_data", data_o, 25);
        check("bp_ready_nonfinal", ready_o, 1);
        send(8'd4); send(8'd4); send(8'd4);
        check("bp_hold_valid", valid_o, 1);
        check("bp_hold_data", data_o, 25);
        valid_i = 1'b1;
        data_i  = 8'd4;
        #1;
        check("bp_ready_low", ready_o, 0);
        @(posedge clk_i);
        #1;
        check("bp_stall_data", data_o, 25);
        check("bp_stall_valid", valid_o, 1);
        check("bp_stall_ready", ready_o, 0);
        ready_i = 1'b1;
        #1;
        check("bp_ready_high", ready_o, 1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        check("bp_new_valid", valid_o, 1);
        check("bp_new_data", data_o, 4);

        // drain and load in the same cycle
        send(8'd6); send(8'd6); send(8'd6);
        check("dl_hold_data", data_o, 4);
        check("dl_hold_valid", valid_o, 1);
        ready_i = 1'b1;
        send(8'd10);
        check("dl_valid_stays", valid_o, 1);
        check("dl_data", data_o, 7);
        idle(1);
        check("dl_drain_valid", valid_o, 0);
        check("dl_drain_data", data_o, 7);

        // sparse input
        send(8'd8);  idle(2);
        send(8'd16); idle(1);
        send(8'd24); idle(3);
        check("sparse_pre_valid", valid_o, 0);
        send(8'd32);
        check("sparse_valid", valid_o, 1);
        check("sparse_data", data_o, 20);
        idle(1);
        check("sparse_one_pulse", valid_o, 0);

        // reset mid-block
        send(8'd100); send(8'd100);
        #3;
        reset_ni = 1'b0;
        #1;
        check("mid_rst_data", data_o, 0);
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_ready", ready_o, 1);
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        send(8'd4); send(8'd8);
        check("mid_rst_no_stale_a", valid_o, 0);
        send(8'd12);
        check("mid_rst_no_stale_b", valid_o, 0);
        send(8'd16);
        check("mid_rst_valid_out", valid_o, 1);
        check("mid_rst_data_out", data_o, 10);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule : tb_decimate_avg

`default_nettype wire
